// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: register-index width,
// FSM state encoding and the control-output bundle driven toward the pipeline.
package pipeline_ctrl_pkg;

  localparam int REG_W   = 5;
  localparam int WAIT_W  = 8;
  localparam int FLUSH_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_FLUSH = 2'd2,
    ERROR    = 2'd3
  } state_t;

  typedef struct packed {
    logic write_pc;
    logic write_ifid;
    logic flush_ctrl_bits;
    logic flush_ifid;
    logic freeze_back;
  } ctrl_t;

  // Canonical output combinations; every state/event picks exactly one of these
  localparam ctrl_t CTRL_RUN    = '{write_pc: 1'b1, write_ifid: 1'b1, flush_ctrl_bits: 1'b0,
                                    flush_ifid: 1'b0, freeze_back: 1'b0};
  localparam ctrl_t CTRL_BUBBLE = '{write_pc: 1'b0, write_ifid: 1'b0, flush_ctrl_bits: 1'b1,
                                    flush_ifid: 1'b0, freeze_back: 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{write_pc: 1'b1, write_ifid: 1'b1, flush_ctrl_bits: 1'b0,
                                    flush_ifid: 1'b1, freeze_back: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{write_pc: 1'b0, write_ifid: 1'b0, flush_ctrl_bits: 1'b0,
                                    flush_ifid: 1'b0, freeze_back: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: a load in ID/EX whose destination feeds either
// source operand of the instruction currently in IF/ID. r0 never creates a hazard.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             mem_read,
  input  logic [REG_W-1:0] rt_idex,
  input  logic [REG_W-1:0] rs_ifid,
  input  logic [REG_W-1:0] rt_ifid,
  output logic             hazard
);

  logic dest_live;
  logic src_match;

  assign dest_live = mem_read && (rt_idex != '0);
  assign src_match = (rt_idex == rs_ifid) || (rt_idex == rt_ifid);
  assign hazard    = dest_live && src_match;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard/stall controller: load-use bubbles, branch IF/ID flushes, memory-busy
// freezes with timeout, and a saturating count of PC-stalled cycles.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int BRANCH_FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT         = 255,
  parameter int CNT_W               = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             memRead_IDEX,
  input  logic [REG_W-1:0] rt_IDEX,
  input  logic [REG_W-1:0] rs_IFID,
  input  logic [REG_W-1:0] rt_IFID,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             write_PC,
  output logic             write_IFID,
  output logic             flush_CtrlBits,
  output logic             flush_IFID,
  output logic             freeze_back,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(BRANCH_FLUSH_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  state_t             state;
  state_t             state_nxt;
  logic [FLUSH_W-1:0] flush_rem;
  logic [FLUSH_W-1:0] flush_rem_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  wait_cnt_nxt;
  logic [CNT_W-1:0]   stall_cnt;
  logic               load_use;
  ctrl_t              ctrl;

  load_use_detect u_load_use_detect (
    .mem_read (memRead_IDEX),
    .rt_idex  (rt_IDEX),
    .rs_ifid  (rs_IFID),
    .rt_ifid  (rt_IFID),
    .hazard   (load_use)
  );

  always_comb begin
    ctrl          = CTRL_RUN;
    state_nxt     = state;
    flush_rem_nxt = flush_rem;
    wait_cnt_nxt  = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_busy) begin
          ctrl         = CTRL_FREEZE;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end else if (load_use) begin
          ctrl = CTRL_BUBBLE;
        end else if (branch_taken) begin
          ctrl = CTRL_FLUSH;
          if (BRANCH_FLUSH_CYCLES > 1) begin
            state_nxt     = BR_FLUSH;
            flush_rem_nxt = FLUSH_INIT;
          end
        end
      end
      BR_FLUSH: begin
        // A freeze here keeps flush_rem so the flush resumes after the wait
        if (mem_busy) begin
          ctrl         = CTRL_FREEZE;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end else begin
          ctrl          = CTRL_FLUSH;
          flush_rem_nxt = flush_rem - 1'b1;
          if (flush_rem == FLUSH_ONE) begin
            state_nxt = RUN;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          ctrl         = CTRL_FREEZE;
          wait_cnt_nxt = wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ERROR;
          end
        end else begin
          state_nxt = (flush_rem != '0) ? BR_FLUSH : RUN;
        end
      end
      ERROR: begin
        ctrl = CTRL_FREEZE;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      flush_rem <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      flush_rem <= flush_rem_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (!ctrl.write_pc && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Reset overrides the input-dependent decode so outputs are idle while held
  assign write_PC        = ctrl.write_pc   | ~reset_n;
  assign write_IFID      = ctrl.write_ifid | ~reset_n;
  assign flush_CtrlBits  = ctrl.flush_ctrl_bits & reset_n;
  assign flush_IFID      = ctrl.flush_ifid      & reset_n;
  assign freeze_back     = ctrl.freeze_back     & reset_n;
  assign mem_timeout_err = (state == ERROR) && reset_n;
  assign stall_count     = stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: a behavioural model predicts
// each cycle's outputs, a separate monitor compares them against the DUT.
module tb_pipeline_stall_controller;

  localparam int BFC     = 3;
  localparam int MT      = 10;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          memRead_IDEX;
  logic [4:0]    rt_IDEX;
  logic [4:0]    rs_IFID;
  logic [4:0]    rt_IFID;
  logic          branch_taken;
  logic          mem_busy;
  logic          write_PC;
  logic          write_IFID;
  logic          flush_CtrlBits;
  logic          flush_IFID;
  logic          freeze_back;
  logic          mem_timeout_err;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .BRANCH_FLUSH_CYCLES (BFC),
    .MEM_TIMEOUT         (MT),
    .CNT_W               (CW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .memRead_IDEX    (memRead_IDEX),
    .rt_IDEX         (rt_IDEX),
    .rs_IFID         (rs_IFID),
    .rt_IFID         (rt_IFID),
    .branch_taken    (branch_taken),
    .mem_busy        (mem_busy),
    .write_PC        (write_PC),
    .write_IFID      (write_IFID),
    .flush_CtrlBits  (flush_CtrlBits),
    .flush_IFID      (flush_IFID),
    .freeze_back     (freeze_back),
    .mem_timeout_err (mem_timeout_err),
    .stall_count     (stall_count)
  );

  typedef struct packed {
    logic          wpc;
    logic          wifid;
    logic          fcb;
    logic          fifid;
    logic          frz;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: pending branch flushes, memory wait length, lock-up, stalls
  int flush_left = 0;
  int waited     = 0;
  bit waiting    = 1'b0;
  bit dead       = 1'b0;
  int stalls     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input bit rn, input bit mr, input int rt, input int rs, input int rtf,
                       input bit br, input bit busy);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    reset_n      = rn;
    memRead_IDEX = mr;
    rt_IDEX      = 5'(rt);
    rs_IFID      = 5'(rs);
    rt_IFID      = 5'(rtf);
    branch_taken = br;
    mem_busy     = busy;
    e = '{wpc: 1'b1, wifid: 1'b1, fcb: 1'b0, fifid: 1'b0, frz: 1'b0, err: 1'b0, cnt: '0};
    if (!rn) begin
      flush_left = 0;
      waited     = 0;
      waiting    = 1'b0;
      dead       = 1'b0;
      stalls     = 0;
    end else begin
      e.cnt = CW'(stalls);
      lu = mr && (rt != 0) && (rt == rs || rt == rtf);
      if (dead) begin
        e.wpc = 1'b0; e.wifid = 1'b0; e.frz = 1'b1; e.err = 1'b1;
      end else if (waiting) begin
        if (busy) begin
          e.wpc = 1'b0; e.wifid = 1'b0; e.frz = 1'b1;
          waited++;
          if (waited == MT) dead = 1'b1;
        end else begin
          waiting = 1'b0;
        end
      end else if (busy) begin
        e.wpc = 1'b0; e.wifid = 1'b0; e.frz = 1'b1;
        waiting = 1'b1;
        waited  = 0;
      end else if (flush_left > 0) begin
        e.fifid = 1'b1;
        flush_left--;
      end else if (lu) begin
        e.wpc = 1'b0; e.wifid = 1'b0; e.fcb = 1'b1;
      end else if (br) begin
        e.fifid    = 1'b1;
        flush_left = BFC - 1;
      end
      if (!e.wpc && stalls < CNT_MAX) stalls++;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic rst_pulse();
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("write_PC",        32'(write_PC),        32'(e.wpc));
        check("write_IFID",      32'(write_IFID),      32'(e.wifid));
        check("flush_CtrlBits",  32'(flush_CtrlBits),  32'(e.fcb));
        check("flush_IFID",      32'(flush_IFID),      32'(e.fifid));
        check("freeze_back",     32'(freeze_back),     32'(e.frz));
        check("mem_timeout_err", 32'(mem_timeout_err), 32'(e.err));
        check("stall_count",     32'(stall_count),     32'(e.cnt));
      end
    end
  end

  initial begin : stimulus
    int busy_pct;
    int guard;
    reset_n = 1'b0; memRead_IDEX = 1'b0; rt_IDEX = '0; rs_IFID = '0; rt_IFID = '0;
    branch_taken = 1'b0; mem_busy = 1'b0;

    // Reset with noisy inputs, then load-use hit, r0 non-hazard, rt match
    drive(1'b0, 1'b1, 5, 5, 5, 1'b1, 1'b1);
    rst_pulse();
    drive(1'b1, 1'b1, 5, 5, 0, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 7, 3, 7, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 7, 7, 7, 1'b0, 1'b0);

    // Branch flush for BFC cycles
    drive(1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(4);

    // Memory busy during the second flush cycle resumes the remaining flush
    rst_pulse();
    drive(1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 3, 3, 3, 1'b1, 1'b1);
    idle(3);

    // All events together: mem_busy dominates
    rst_pulse();
    drive(1'b1, 1'b1, 5, 5, 0, 1'b1, 1'b1);
    idle(2);

    // Timeout into ERROR, stall counter saturation, reset clears it
    rst_pulse();
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(CNT_MAX + 5);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(3);

    // Randomized traffic with varying memory pressure and occasional resets
    busy_pct = 20;
    for (int i = 0; i < 1200; i++) begin
      if (i % 100 == 0) busy_pct = (busy_pct == 20) ? 92 : 20;
      drive($urandom_range(0, 79) != 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            $urandom_range(0, 5) == 0, int'($urandom_range(0, 99)) < busy_pct);
    end

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb.size() > 0) check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
